// File: rtl/id_ex_skid_stage.sv
// ID/EX pipeline stage: valid/ready handshake, 2-entry skid buffer, synchronous flush.
// Optional write-back bypass into captured operands is enabled by defining ID_EX_WB_BYPASS_EN.
module id_ex_skid_stage #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5,
  parameter int CTRL_W = 11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_d,
  output logic              ready_d,
  input  logic [CTRL_W-1:0] ctrl_d,
  input  logic [REG_AW-1:0] rs1_d,
  input  logic [REG_AW-1:0] rs2_d,
  input  logic [REG_AW-1:0] rd_d,
  input  logic [XLEN-1:0]   rd1_d,
  input  logic [XLEN-1:0]   rd2_d,
  input  logic [XLEN-1:0]   pc_d,
  input  logic [XLEN-1:0]   imm_d,
  input  logic [XLEN-1:0]   pc_plus4_d,
  input  logic              we_w,
  input  logic [REG_AW-1:0] rd_w,
  input  logic [XLEN-1:0]   wd_w,
  input  logic              flush_e,
  output logic              valid_e,
  input  logic              ready_e,
  output logic [CTRL_W-1:0] ctrl_e,
  output logic [REG_AW-1:0] rs1_e,
  output logic [REG_AW-1:0] rs2_e,
  output logic [REG_AW-1:0] rd_e,
  output logic [XLEN-1:0]   rd1_e,
  output logic [XLEN-1:0]   rd2_e,
  output logic [XLEN-1:0]   pc_e,
  output logic [XLEN-1:0]   imm_e,
  output logic [XLEN-1:0]   pc_plus4_e
);

  typedef struct packed {
    logic [CTRL_W-1:0] ctrl;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   rd1;
    logic [XLEN-1:0]   rd2;
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   imm;
    logic [XLEN-1:0]   pc4;
  } beat_t;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  state_t r_state;
  state_t w_nxt_state;
  logic   r_ready;
  beat_t  r_main;
  beat_t  r_skid;
  beat_t  w_in_beat;
  logic   w_in;
  logic   w_out;
  logic   w_valid;
  logic   w_ld_main_in;
  logic   w_ld_main_skid;
  logic   w_ld_skid_in;

`ifdef ID_EX_WB_BYPASS_EN
  // Keeps an operand coherent with the register-file write happening this cycle; x0 is never bypassed.
  function automatic beat_t f_bypass(input beat_t b);
    beat_t r;
    r = b;
    if (we_w && (rd_w != '0)) begin
      if (b.rs1 == rd_w) r.rd1 = wd_w;
      if (b.rs2 == rd_w) r.rd2 = wd_w;
    end
    return r;
  endfunction
`else
  function automatic beat_t f_bypass(input beat_t b);
    return b;
  endfunction

  logic w_unused_wb;
  assign w_unused_wb = ^{we_w, rd_w, wd_w};
`endif

  assign w_in_beat = '{ctrl: ctrl_d, rs1: rs1_d, rs2: rs2_d, rd: rd_d,
                       rd1: rd1_d, rd2: rd2_d, pc: pc_d, imm: imm_d, pc4: pc_plus4_d};

  assign w_valid = (r_state != ST_EMPTY);
  assign w_in    = valid_d && r_ready;
  assign w_out   = w_valid && ready_e;

  always_comb begin
    w_nxt_state    = r_state;
    w_ld_main_in   = 1'b0;
    w_ld_main_skid = 1'b0;
    w_ld_skid_in   = 1'b0;
    case (r_state)
      ST_EMPTY: begin
        if (w_in) begin
          w_nxt_state  = ST_ONE;
          w_ld_main_in = 1'b1;
        end
      end
      ST_ONE: begin
        if (w_in && w_out) begin
          w_ld_main_in = 1'b1;
        end else if (w_in) begin
          w_nxt_state  = ST_TWO;
          w_ld_skid_in = 1'b1;
        end else if (w_out) begin
          w_nxt_state  = ST_EMPTY;
        end
      end
      ST_TWO: begin
        if (w_out) begin
          w_nxt_state    = ST_ONE;
          w_ld_main_skid = 1'b1;
        end
      end
      default: w_nxt_state = ST_EMPTY;
    endcase
    // Flush wins over everything, including a beat accepted in the same cycle.
    if (flush_e) begin
      w_nxt_state    = ST_EMPTY;
      w_ld_main_in   = 1'b0;
      w_ld_main_skid = 1'b0;
      w_ld_skid_in   = 1'b0;
    end
  end

  // ready_d comes straight from a flop so ready_e never reaches the decode side combinationally.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_EMPTY;
      r_ready <= 1'b0;
    end else begin
      r_state <= w_nxt_state;
      r_ready <= (w_nxt_state != ST_TWO);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_main <= '0;
      r_skid <= '0;
    end else begin
      if (w_ld_main_in)        r_main <= f_bypass(w_in_beat);
      else if (w_ld_main_skid) r_main <= f_bypass(r_skid);
      else                     r_main <= f_bypass(r_main);

      if (w_ld_skid_in) r_skid <= f_bypass(w_in_beat);
      else              r_skid <= f_bypass(r_skid);
    end
  end

  assign ready_d    = r_ready;
  assign valid_e    = w_valid;
  assign ctrl_e     = w_valid ? r_main.ctrl : '0;
  assign rs1_e      = r_main.rs1;
  assign rs2_e      = r_main.rs2;
  assign rd_e       = r_main.rd;
  assign rd1_e      = r_main.rd1;
  assign rd2_e      = r_main.rd2;
  assign pc_e       = r_main.pc;
  assign imm_e      = r_main.imm;
  assign pc_plus4_e = r_main.pc4;

endmodule

// File: tb/tb_id_ex_skid_stage.sv
// Directed bench for id_ex_skid_stage: stimulus pushes expected beats, a negedge monitor pops and compares.
module tb_id_ex_skid_stage;
  localparam int XLEN   = 32;
  localparam int REG_AW = 5;
  localparam int CTRL_W = 11;

`ifdef ID_EX_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              valid_d, ready_d;
  logic [CTRL_W-1:0] ctrl_d;
  logic [REG_AW-1:0] rs1_d, rs2_d, rd_d;
  logic [XLEN-1:0]   rd1_d, rd2_d, pc_d, imm_d, pc_plus4_d;
  logic              we_w;
  logic [REG_AW-1:0] rd_w;
  logic [XLEN-1:0]   wd_w;
  logic              flush_e;
  logic              valid_e, ready_e;
  logic [CTRL_W-1:0] ctrl_e;
  logic [REG_AW-1:0] rs1_e, rs2_e, rd_e;
  logic [XLEN-1:0]   rd1_e, rd2_e, pc_e, imm_e, pc_plus4_e;

  id_ex_skid_stage #(.XLEN(XLEN), .REG_AW(REG_AW), .CTRL_W(CTRL_W)) dut (
    .clk(clk), .rst(rst),
    .valid_d(valid_d), .ready_d(ready_d), .ctrl_d(ctrl_d),
    .rs1_d(rs1_d), .rs2_d(rs2_d), .rd_d(rd_d),
    .rd1_d(rd1_d), .rd2_d(rd2_d), .pc_d(pc_d), .imm_d(imm_d), .pc_plus4_d(pc_plus4_d),
    .we_w(we_w), .rd_w(rd_w), .wd_w(wd_w), .flush_e(flush_e),
    .valid_e(valid_e), .ready_e(ready_e), .ctrl_e(ctrl_e),
    .rs1_e(rs1_e), .rs2_e(rs2_e), .rd_e(rd_e),
    .rd1_e(rd1_e), .rd2_e(rd2_e), .pc_e(pc_e), .imm_e(imm_e), .pc_plus4_e(pc_plus4_e)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [10:0] ctrl;
    logic [31:0] rd1;
    logic [31:0] rd2;
  } exp_t;

  exp_t q[$];
  exp_t m_e;
  int   n_assert = 0;
  int   n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [10:0] ctrl_of(input logic [31:0] pc);
    return pc[10:0] ^ 11'h7A1;
  endfunction

  task automatic drive(input logic v, input logic [31:0] pc, input logic [4:0] rs1,
                       input logic [31:0] rd1, input logic [4:0] rs2, input logic [31:0] rd2);
    valid_d    = v;
    pc_d       = pc;
    imm_d      = pc ^ 32'h0000_F000;
    pc_plus4_d = pc + 32'd4;
    ctrl_d     = ctrl_of(pc);
    rs1_d      = rs1;
    rs2_d      = rs2;
    rd_d       = 5'd3;
    rd1_d      = rd1;
    rd2_d      = rd2;
  endtask

  task automatic push(input logic [31:0] pc, input logic [31:0] rd1, input logic [31:0] rd2);
    exp_t e;
    e.pc   = pc;
    e.ctrl = ctrl_of(pc);
    e.rd1  = rd1;
    e.rd2  = rd2;
    q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every beat leaving the stage must match the oldest expected beat.
  always @(negedge clk) begin
    if (rst && valid_e && ready_e) begin
      if (q.size() == 0) begin
        n_assert++;
        n_fail++;
        $display("FAIL unexpected_beat: got pc 0x%0h, expected no beat", pc_e);
      end else begin
        m_e = q.pop_front();
        chk("out_pc", pc_e, m_e.pc);
        chk("out_ctrl", 32'(ctrl_e), 32'(m_e.ctrl));
        chk("out_rd1", rd1_e, m_e.rd1);
        chk("out_rd2", rd2_e, m_e.rd2);
        chk("out_pc4", pc_plus4_e, m_e.pc + 32'd4);
        chk("out_imm", imm_e, m_e.pc ^ 32'h0000_F000);
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "watchdog expired");
  end

  initial begin
    drive(1'b0, 32'h0, 5'd0, 32'h0, 5'd0, 32'h0);
    we_w = 1'b0; rd_w = '0; wd_w = '0; flush_e = 1'b0; ready_e = 1'b0;
    #2;
    chk("rst_valid_e", 32'(valid_e), 32'd0);
    chk("rst_ctrl_e", 32'(ctrl_e), 32'd0);
    chk("rst_pc_e", pc_e, 32'd0);
    chk("rst_ready_d", 32'(ready_d), 32'd0);
    #10 rst = 1'b1;
    step();

    // Stream three beats at full rate
    ready_e = 1'b1;
    chk("idle_ready_d", 32'(ready_d), 32'd1);
    chk("idle_valid_e", 32'(valid_e), 32'd0);
    drive(1'b1, 32'h0, 5'd1, 32'h100, 5'd2, 32'h200); push(32'h0, 32'h100, 32'h200);
    step();
    chk("lat_valid_e", 32'(valid_e), 32'd1);
    chk("stream_ready0", 32'(ready_d), 32'd1);
    drive(1'b1, 32'h4, 5'd1, 32'h104, 5'd2, 32'h204); push(32'h4, 32'h104, 32'h204);
    step();
    chk("stream_ready1", 32'(ready_d), 32'd1);
    chk("stream_pc4", pc_e, 32'h4);
    drive(1'b1, 32'h8, 5'd1, 32'h108, 5'd2, 32'h208); push(32'h8, 32'h108, 32'h208);
    step();
    chk("stream_pc8", pc_e, 32'h8);
    valid_d = 1'b0;
    step();
    chk("drain_valid_e", 32'(valid_e), 32'd0);
    chk("bubble_ctrl_e", 32'(ctrl_e), 32'd0);
    chk("bubble_pc_hold", pc_e, 32'h8);

    // Stall with a beat landing in the skid entry
    drive(1'b1, 32'h10, 5'd1, 32'h110, 5'd2, 32'h210); push(32'h10, 32'h110, 32'h210);
    step();
    chk("stall_main_pc", pc_e, 32'h10);
    ready_e = 1'b0;
    drive(1'b1, 32'h14, 5'd1, 32'h114, 5'd2, 32'h214); push(32'h14, 32'h114, 32'h214);
    step();
    chk("stall_ready_d", 32'(ready_d), 32'd0);
    chk("stall_pc_held", pc_e, 32'h10);
    valid_d = 1'b0;
    step();
    chk("stall_ready_d2", 32'(ready_d), 32'd0);
    chk("stall_valid_e", 32'(valid_e), 32'd1);
    ready_e = 1'b1;
    step();
    chk("unstall_pc14", pc_e, 32'h14);
    chk("unstall_ready_d", 32'(ready_d), 32'd1);
    step();
    chk("unstall_empty", 32'(valid_e), 32'd0);

    // Flush from TWO with a beat offered
    ready_e = 1'b0;
    drive(1'b1, 32'h20, 5'd1, 32'h120, 5'd2, 32'h220); push(32'h20, 32'h120, 32'h220);
    step();
    drive(1'b1, 32'h24, 5'd1, 32'h124, 5'd2, 32'h224); push(32'h24, 32'h124, 32'h224);
    step();
    chk("pre_flush_ready_d", 32'(ready_d), 32'd0);
    flush_e = 1'b1;
    drive(1'b1, 32'h28, 5'd1, 32'h128, 5'd2, 32'h228);
    q.delete();
    step();
    chk("flush2_valid_e", 32'(valid_e), 32'd0);
    chk("flush2_ctrl_e", 32'(ctrl_e), 32'd0);
    chk("flush2_ready_d", 32'(ready_d), 32'd1);

    // Flush from ONE while a beat is actually accepted
    flush_e = 1'b0;
    drive(1'b1, 32'h30, 5'd1, 32'h130, 5'd2, 32'h230); push(32'h30, 32'h130, 32'h230);
    step();
    chk("flush1_main_pc", pc_e, 32'h30);
    flush_e = 1'b1;
    drive(1'b1, 32'h34, 5'd1, 32'h134, 5'd2, 32'h234);
    q.delete();
    step();
    chk("flush1_valid_e", 32'(valid_e), 32'd0);
    chk("flush1_ready_d", 32'(ready_d), 32'd1);
    flush_e = 1'b0;
    valid_d = 1'b0;
    ready_e = 1'b1;
    step();
    chk("flush1_stays_empty", 32'(valid_e), 32'd0);
    step();

    // Bypass into an incoming beat, and the x0 guard
    we_w = 1'b1; rd_w = 5'd5; wd_w = 32'hAB;
    drive(1'b1, 32'h40, 5'd5, 32'h11, 5'd6, 32'h22);
    push(32'h40, BYP ? 32'hAB : 32'h11, 32'h22);
    step();
    chk("byp_in_rd1", rd1_e, BYP ? 32'hAB : 32'h11);
    rd_w = 5'd0; wd_w = 32'hCD;
    drive(1'b1, 32'h44, 5'd0, 32'h11, 5'd6, 32'h22);
    push(32'h44, 32'h11, 32'h22);
    step();
    chk("byp_x0_rd1", rd1_e, 32'h11);
    we_w = 1'b0;
    valid_d = 1'b0;
    step();

    // Bypass into held main and skid entries while stalled
    ready_e = 1'b0;
    drive(1'b1, 32'h50, 5'd1, 32'h01, 5'd7, 32'h77);
    push(32'h50, 32'h01, BYP ? 32'h55 : 32'h77);
    step();
    drive(1'b1, 32'h54, 5'd9, 32'h99, 5'd2, 32'h22);
    push(32'h54, BYP ? 32'h66 : 32'h99, 32'h22);
    step();
    chk("byp_two_ready_d", 32'(ready_d), 32'd0);
    valid_d = 1'b0;
    we_w = 1'b1; rd_w = 5'd7; wd_w = 32'h55;
    step();
    chk("byp_stall_rd2", rd2_e, BYP ? 32'h55 : 32'h77);
    rd_w = 5'd9; wd_w = 32'h66;
    step();
    chk("byp_stall_rd2_keep", rd2_e, BYP ? 32'h55 : 32'h77);
    chk("byp_stall_rd1_keep", rd1_e, 32'h01);
    we_w = 1'b0;
    ready_e = 1'b1;
    step();
    chk("byp_skid_rd1", rd1_e, BYP ? 32'h66 : 32'h99);
    step();
    chk("byp_drained", 32'(valid_e), 32'd0);

    // Asynchronous reset while holding two beats
    ready_e = 1'b0;
    drive(1'b1, 32'h60, 5'd1, 32'h160, 5'd2, 32'h260); push(32'h60, 32'h160, 32'h260);
    step();
    drive(1'b1, 32'h64, 5'd1, 32'h164, 5'd2, 32'h264); push(32'h64, 32'h164, 32'h264);
    step();
    valid_d = 1'b0;
    #3 rst = 1'b0;
    #1;
    chk("arst_valid_e", 32'(valid_e), 32'd0);
    chk("arst_pc_e", pc_e, 32'd0);
    chk("arst_ctrl_e", 32'(ctrl_e), 32'd0);
    chk("arst_rd1_e", rd1_e, 32'd0);
    chk("arst_rd2_e", rd2_e, 32'd0);
    chk("arst_ready_d", 32'(ready_d), 32'd0);
    q.delete();
    #3 rst = 1'b1;
    step();
    chk("post_rst_ready_d", 32'(ready_d), 32'd1);
    chk("post_rst_valid_e", 32'(valid_e), 32'd0);
    ready_e = 1'b1;
    drive(1'b1, 32'h70, 5'd1, 32'h170, 5'd2, 32'h270); push(32'h70, 32'h170, 32'h270);
    step();
    chk("post_rst_beat_valid", 32'(valid_e), 32'd1);
    chk("post_rst_beat_pc", pc_e, 32'h70);
    valid_d = 1'b0;
    step();
    chk("queue_drained", 32'(q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/id_ex_skid_stage.md
# id_ex_skid_stage

Parametrised ID/EX pipeline stage with valid/ready flow control. It sits between the decode stage (control unit, register file, immediate generator) and the execute stage, and replaces a free-running ID/EX register. It adds four things: back-pressure through a 2-entry skid buffer, synchronous flush (bubble insertion), configurable data and control widths, and an optional write-back bypass that keeps captured operands coherent with register-file writes.

## Interface
Parameters:
- XLEN, 32: data/PC/immediate width
- REG_AW, 5: register address width
- CTRL_W, 11: packed control bundle width (RegWrite, MemWrite, Jump, Branch, ALUSrc, ResultSrc[1:0], ALU_Ctrl[2:0], spare)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- valid_d  in  1  decode beat valid
- ready_d  out  1  stage can accept a beat
- ctrl_d  in  CTRL_W  decoded control bundle
- rs1_d, rs2_d, rd_d  in  REG_AW  source/destination register addresses
- rd1_d, rd2_d  in  XLEN  register-file read data
- pc_d, imm_d, pc_plus4_d  in  XLEN  PC, extended immediate, PC+4
- we_w  in  1  write-back register write enable
- rd_w  in  REG_AW  write-back destination
- wd_w  in  XLEN  write-back data
- flush_e  in  1  synchronous kill of all held beats
- valid_e  out  1  execute beat valid
- ready_e  in  1  execute accepts beat
- ctrl_e, rs1_e, rs2_e, rd_e, rd1_e, rd2_e, pc_e, imm_e, pc_plus4_e  out  widths as inputs  registered beat

## Operation
- Storage is a main entry (drives outputs) plus a skid entry. Each entry holds all payload fields and a valid bit.
- Transfer in: valid_d && ready_d. Transfer out: valid_e && ready_e.
- ready_d = !skid_valid, driven from a register. There is no combinational path from ready_e to ready_d.
- States:
  - EMPTY (no entry valid): in -> ONE.
  - ONE (main valid):
    - in && out -> ONE, main reloaded.
    - in && !out -> TWO, beat goes to skid.
    - !in && out -> EMPTY.
    - otherwise ONE, main held.
  - TWO (main and skid valid): out -> ONE, skid moves to main. Otherwise hold.
- Beat order is strictly preserved. No beat is duplicated or dropped, except by flush.
- flush_e = 1:
  - Next state is EMPTY.
  - Any beat transferred in that same cycle is discarded.
  - Flush has priority over every other event.
- When valid_e = 0, ctrl_e is forced to 0 so execute sees a bubble. Other outputs hold their last values.
- Reset (rst = 0, async): all outputs 0, valid_e = 0, skid empty. ready_d = 1 from the first edge after release.

## Timing
- Latency: a beat accepted at edge N appears on outputs after edge N, provided main is empty or draining.
- Full throughput (1 beat/cycle) is sustained while ready_e = 1.
- ready_e dropping at cycle N: one more beat can be accepted at edge N (into skid). ready_d is 0 from edge N onward.
- ready_d returns to 1 the cycle after skid drains into main.
- Reset asserted mid-operation clears both entries immediately. No beat survives.

## Configuration
- ID_EX_WB_BYPASS_EN defined: every cycle with we_w = 1 and rd_w != 0:
  - Incoming beat: rd1 captures wd_w when rs1_d == rd_w, and rd2 captures wd_w when rs2_d == rd_w.
  - Held entries (main and skid): rd1/rd2 are overwritten in place with wd_w when rs1/rs2 equals rd_w.
  - Applies in all states, including while stalled.
  - A write to x0 is never bypassed.
- ID_EX_WB_BYPASS_EN undefined: rd1_d/rd2_d are captured verbatim, held entries are never modified, and the we_w/rd_w/wd_w inputs are unused.

## Test plan
- Reset then stream: stream pc_d = 0x0, 0x4, 0x8 with ready_e = 1 -> valid_e rises one cycle after the first accept, pc_e = 0x0, 0x4, 0x8 on consecutive cycles, ready_d stays 1.
- Stall: ready_e = 0 while pc 0x10 is in main and 0x14 is offered -> 0x14 goes to skid and ready_d = 0. After ready_e = 1: outputs 0x10, then 0x14, then ready_d = 1. No loss, no duplication.
- Flush with simultaneous input: TWO state plus flush_e = 1 with valid_d = 1 -> next cycle valid_e = 0, ctrl_e = 0, ready_d = 1. The offered beat never appears.
- Bypass, incoming beat (macro defined): rs1_d = 5, rd1_d = 0x11, we_w = 1, rd_w = 5, wd_w = 0xAB -> rd1_e = 0xAB. With rd_w = 0, rd1_e = 0x11.
- Bypass, stalled beat: beat with rs2 = 7 held in main under ready_e = 0, then a write to x7 of 0x55 -> rd2_e = 0x55 before the beat is accepted. With the macro undefined, rd2_e is unchanged.
- Async reset mid-stall: rst = 0 between clock edges while in TWO -> valid_e = 0 and all outputs 0 immediately. After release, the next beat passes normally.
